delay_off_ms: RTL

DELAY_OFF_MS -- requirements
Module: delay_off_ms

---
 rtl/delay_off_pkg.sv | 15 +
 rtl/ms_timer.sv | 22 ++
 rtl/delay_off_ms.sv | 103 ++++++++++
 3 files changed

// File: rtl/delay_off_pkg.sv
// delay_off_pkg: FSM state encodings and ms-to-cycles conversion shared by the delay-off block.
package delay_off_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ON      = 2'd1,
        ST_HOLD    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    function automatic logic [31:0] ms_to_cycles(input int unsigned ms, input int unsigned mhz);
        return 32'(ms * mhz * 1000);
    endfunction

endpackage

// File: rtl/ms_timer.sv
// ms_timer: 32-bit saturating cycle counter with clear, enable and terminal-count compare.
module ms_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [31:0] i_terminal,
    output logic        o_done
);

    logic [31:0] r_count = '0;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clear)
            r_count <= '0;
        else if (i_enable && r_count != '1)
            r_count <= r_count + 32'd1;
    end

    assign o_done = r_count == i_terminal;

endmodule

// File: rtl/delay_off_ms.sv
// delay_off_ms: enable with delayed turn-off and a minimum off (lockout) time.
// Optional DELAY_OFF_FORCE_EN adds a force_off input that jumps straight into lockout.
module delay_off_ms
    import delay_off_pkg::*;
#(
    parameter int unsigned C_CLK_MHZ    = 100,
    parameter int unsigned C_HOLD_MS    = 2,
    parameter int unsigned C_LOCKOUT_MS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_signal,
`ifdef DELAY_OFF_FORCE_EN
    input  logic       force_off,
`endif
    output logic       delayed,
    output logic       holding,
    output logic       locked,
    output logic [1:0] state
);

    localparam logic [31:0] N_HOLD = ms_to_cycles(C_HOLD_MS, C_CLK_MHZ);
    localparam logic [31:0] N_LOCK = ms_to_cycles(C_LOCKOUT_MS, C_CLK_MHZ);
    // A zero-length lockout collapses straight to OFF.
    localparam state_t ST_AFTER_HOLD = (N_LOCK == 32'd0) ? ST_OFF : ST_LOCKOUT;

    state_t      r_state   = ST_OFF;
    logic        r_delayed = 1'b0;
    logic        r_holding = 1'b0;
    logic        r_locked  = 1'b0;
    state_t      w_next;
    logic        w_force;
    logic        w_restart;
    logic        w_done;
    logic        w_clear;
    logic        w_enable;
    logic [31:0] w_terminal;
    logic        w_delayed;
    logic        w_holding;
    logic        w_locked;

`ifdef DELAY_OFF_FORCE_EN
    assign w_force = force_off;
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_OFF;
            r_delayed <= 1'b0;
            r_holding <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_delayed <= w_delayed;
            r_holding <= w_holding;
            r_locked  <= w_locked;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_restart = 1'b0;
        case (r_state)
            ST_OFF:     w_next = (in_signal && !w_force) ? ST_ON : ST_OFF;
            ST_ON:      w_next = w_force ? ST_AFTER_HOLD : in_signal ? ST_ON :
                                 (N_HOLD == 32'd0) ? ST_AFTER_HOLD : ST_HOLD;
            ST_HOLD:    w_next = w_force ? ST_AFTER_HOLD : in_signal ? ST_ON :
                                 w_done ? ST_AFTER_HOLD : ST_HOLD;
            ST_LOCKOUT: begin
                w_next    = (w_done && !w_force) ? ST_OFF : ST_LOCKOUT;
                w_restart = w_force;
            end
        endcase
    end

    always_comb begin
        w_delayed = w_next == ST_ON || w_next == ST_HOLD;
        w_holding = w_next == ST_HOLD;
        w_locked  = w_next == ST_LOCKOUT;
    end

    // Counter restarts on every state change so HOLD and LOCKOUT each count from zero.
    assign w_clear    = (w_next != r_state) || w_restart;
    assign w_enable   = r_state == ST_HOLD || r_state == ST_LOCKOUT;
    assign w_terminal = ((r_state == ST_HOLD) ? N_HOLD : N_LOCK) - 32'd1;

    ms_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_clear),
        .i_enable   (w_enable),
        .i_terminal (w_terminal),
        .o_done     (w_done)
    );

    assign delayed = r_delayed;
    assign holding = r_holding;
    assign locked  = r_locked;
    assign state   = r_state;

endmodule
